// File: rtl/button_repeat.sv
// button_repeat: turns a debounced, clk-synchronous button level into
// single-cycle event strobes with auto-repeat while the button is held.
//
// Parameters
//   HOLD_CYCLES   cycles from the press strobe to the first repeat strobe (>= 2)
//   REPEAT_CYCLES cycles between successive repeat strobes (>= 2)
//   CNT_W         counter width; must hold max(HOLD_CYCLES, REPEAT_CYCLES) - 1
//
// Ports
//   clk           system clock, rising-edge active
//   reset         asynchronous, active-high reset
//   in            debounced button level (synchronous, glitch-free)
//   pulse         one-cycle strobe on press and on every auto-repeat
//   release_pulse one-cycle strobe when the button is released
//   held          high from the first repeat strobe until release
//
// All outputs are registered; nothing in this block is combinational from
// in to an output.

module button_repeat #(
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse,
    output logic release_pulse,
    output logic held
);

    // Terminal counts, pre-sized to the counter width.
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_q;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;
    logic             held_q, held_d;

    // State and output registers. in_q resets to 0 so that a button already
    // held when reset deasserts is seen as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            in_q      <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_q      <= in;
            pulse_q   <= pulse_d;
            release_q <= release_d;
            held_q    <= held_d;
        end
    end

    // Next-state and next-output logic. Strobes default low every cycle;
    // release takes priority over a terminal count on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        held_d    = held_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                held_d = 1'b0;
                if (in && !in_q) begin
                    pulse_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!in) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    pulse_d = 1'b1;
                    held_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_REPEAT: begin
                if (!in) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                // Unused encoding: recover to a clean idle.
                state_d = ST_IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    assign pulse         = pulse_q;
    assign release_pulse = release_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_repeat.sv
// Self-checking bench for button_repeat with HOLD_CYCLES=8, REPEAT_CYCLES=4.
// A run-length model predicts every output cycle; directed windows also pin
// exact strobe positions with hand-computed bit masks.

module tb_button_repeat;

    localparam int H = 8;
    localparam int R = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic in    = 1'b0;
    logic pulse, release_pulse, held;

    int checks = 0;
    int errors = 0;

    logic [63:0] p_log, r_log, h_log;

    always #5 clk = ~clk;

    button_repeat #(
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .pulse        (pulse),
        .release_pulse(release_pulse),
        .held         (held)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: k = number of edges since the press edge while in stays high.
    // Press at k=0, repeats at k = H, H+R, H+2R, ...; release when in drops.
    logic m_prev = 1'b0;
    int   m_run  = 0;
    logic e_p = 1'b0, e_r = 1'b0, e_h = 1'b0;

    function automatic logic model_pulse(input int k);
        return (k == 0) || (k >= H && ((k - H) % R) == 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev <= 1'b0;
            m_run  <= 0;
            e_p    <= 1'b0;
            e_r    <= 1'b0;
            e_h    <= 1'b0;
        end else begin
            if (in) begin
                m_run <= m_prev ? m_run + 1 : 1;
                e_p   <= model_pulse(m_prev ? m_run : 0);
                e_h   <= (m_prev ? m_run : 0) >= H;
                e_r   <= 1'b0;
            end else begin
                m_run <= 0;
                e_p   <= 1'b0;
                e_h   <= 1'b0;
                e_r   <= m_prev;
            end
            m_prev <= in;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("model_pulse", 64'(pulse), 64'(e_p));
            chk("model_release", 64'(release_pulse), 64'(e_r));
            chk("model_held", 64'(held), 64'(e_h));
            if (pulse && release_pulse) begin
                chk("pulse_and_release_exclusive", 64'd1, 64'd0);
            end
        end
    end

    // Cycle c is the interval after the c-th posedge of the window; in is
    // driven to pat[c] during cycle c and outputs are logged mid-cycle.
    task automatic drive_window(input int n, input logic [63:0] pat);
        p_log = '0;
        r_log = '0;
        h_log = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1 in = pat[c];
            @(negedge clk);
            p_log[c] = pulse;
            r_log[c] = release_pulse;
            h_log[c] = held;
        end
    endtask

    function automatic logic [63:0] ones(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bits(input int a, input int b, input int c2, input int d);
        logic [63:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c2 >= 0) m[c2] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        return m;
    endfunction

    initial begin
        // Reset state.
        #1;
        chk("reset_pulse", 64'(pulse), 64'd0);
        chk("reset_release", 64'(release_pulse), 64'd0);
        chk("reset_held", 64'(held), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Short press: high cycles 10..12.
        drive_window(20, ones(10, 12));
        chk("short_pulse", p_log, bits(11, -1, -1, -1));
        chk("short_release", r_log, bits(14, -1, -1, -1));
        chk("short_held", h_log, 64'd0);

        // Long hold: high cycles 10..39.
        drive_window(48, ones(10, 39));
        chk("long_pulse", p_log, bits(11, 19, 23, 27) | bits(31, 35, 39, -1));
        chk("long_release", r_log, bits(41, -1, -1, -1));
        chk("long_held", h_log, ones(19, 40));

        // Release on the edge of a REPEAT terminal count (edge 23).
        drive_window(28, ones(10, 21));
        chk("term_pulse", p_log, bits(11, 19, -1, -1));
        chk("term_release", r_log, bits(23, -1, -1, -1));
        chk("term_held", h_log, ones(19, 22));

        // Alternating high/low/high/low.
        drive_window(20, bits(10, 12, -1, -1));
        chk("alt_pulse", p_log, bits(11, 13, -1, -1));
        chk("alt_release", r_log, bits(12, 14, -1, -1));
        chk("alt_held", h_log, 64'd0);

        // Async reset mid-cycle while held=1 in REPEAT.
        drive_window(24, ones(10, 40));
        @(posedge clk);
        #3;
        chk("pre_reset_held", 64'(held), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_pulse", 64'(pulse), 64'd0);
        chk("async_release", 64'(release_pulse), 64'd0);
        chk("async_held", 64'(held), 64'd0);
        in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_window(20, 64'd0);
        chk("quiet_pulse", p_log, 64'd0);
        chk("quiet_release", r_log, 64'd0);
        chk("quiet_held", h_log, 64'd0);

        // Button held through reset release counts as a press.
        @(negedge clk);
        in    = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_window(16, ones(0, 9));
        chk("held_rst_pulse", p_log, bits(0, 8, -1, -1));
        chk("held_rst_release", r_log, bits(11, -1, -1, -1));
        chk("held_rst_held", h_log, ones(8, 10));

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
